// File: rtl/rgb_to_gray_stream.sv
// rgb_to_gray_stream
// ------------------
// Streaming colour-to-luma converter. Bytes arrive as an interleaved
// R,G,B stream, one byte per accepted cycle. Each completed triple yields one
// 8-bit grey pixel:
//   grey = (77*R + 150*G + 29*B + RND) >> 8
// The pixel also carries end-of-line and end-of-frame markers for a
// WIDTH x HEIGHT raster.
//
// Build option:
//   GRAY_ROUND_EN  defined   -> RND = 128 (round-half-up luma)
//                  undefined -> RND = 0   (truncating luma)
//   Latency, markers and counters are the same in both builds.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data carries a colour byte this cycle
//   in_sof     with in_valid: this byte is R of pixel (0,0)
//   in_data    colour byte, order R, G, B repeating
//   out_valid  one-cycle pulse, out_data holds a new grey pixel
//   out_data   grey value, held between pulses
//   out_eol    qualifies out_valid: last pixel of a line
//   out_eof    qualifies out_valid: last pixel of the frame
//
// There is no backpressure. The consumer must take every pulse. Under
// continuous input, one pulse is produced every 3 clocks.

module rgb_to_gray_stream #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 1280
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_eol,
    output logic       out_eof
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

`ifdef GRAY_ROUND_EN
    localparam logic [15:0] RND = 16'd128;
`else
    localparam logic [15:0] RND = 16'd0;
`endif

    // Luma weights. They sum to 256, so the worst case is
    // 65280 + 128 = 65408. This fits in 16 bits, and the result never
    // exceeds 255.
    localparam logic [15:0] W_R = 16'd77;
    localparam logic [15:0] W_G = 16'd150;
    localparam logic [15:0] W_B = 16'd29;

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [15:0]        acc_q,   acc_d;
    logic [COL_W-1:0]   col_q,   col_d;
    logic [ROW_W-1:0]   row_q,   row_d;
    logic               vld_q,   vld_d;
    logic [7:0]         data_q,  data_d;
    logic               eol_q,   eol_d;
    logic               eof_q,   eof_d;

    logic [15:0]        byte_w;
    logic [15:0]        r_term;
    logic [15:0]        g_sum;
    logic [15:0]        b_sum;
    logic               line_end;
    logic               frame_end;

    assign byte_w    = 16'(in_data);
    assign r_term    = byte_w * W_R + RND;
    assign g_sum     = acc_q + byte_w * W_G;
    assign b_sum     = acc_q + byte_w * W_B;
    assign line_end  = (col_q == COL_LAST);
    assign frame_end = (row_q == ROW_LAST);

    always_comb begin
        phase_d = phase_q;
        acc_d   = acc_q;
        col_d   = col_q;
        row_d   = row_q;
        vld_d   = 1'b0;
        data_d  = data_q;
        eol_d   = 1'b0;
        eof_d   = 1'b0;

        if (in_valid) begin
            if (in_sof) begin
                // Start of frame. This drops any partial triple, even when
                // the byte lands in the B slot. The byte is then treated as
                // R of pixel (0,0).
                acc_d   = r_term;
                phase_d = PH_G;
                col_d   = '0;
                row_d   = '0;
            end else begin
                case (phase_q)
                    PH_R: begin
                        acc_d   = r_term;
                        phase_d = PH_G;
                    end
                    PH_G: begin
                        acc_d   = g_sum;
                        phase_d = PH_B;
                    end
                    PH_B: begin
                        vld_d   = 1'b1;
                        data_d  = 8'(b_sum >> 8);
                        eol_d   = line_end;
                        eof_d   = line_end && frame_end;
                        phase_d = PH_R;
                        if (line_end) begin
                            col_d = '0;
                            row_d = frame_end ? '0 : row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                    default: begin
                        // The unused encoding recovers by treating this
                        // byte as R.
                        acc_d   = r_term;
                        phase_d = PH_G;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_R;
            acc_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= 8'h00;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
            col_q   <= col_d;
            row_q   <= row_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
module tb_rgb_to_gray_stream;

    localparam int TW = 4;
    localparam int TH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_eol;
    logic       out_eof;

    rgb_to_gray_stream #(.WIDTH(TW), .HEIGHT(TH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       eol;
        logic       eof;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pos = 0;
    logic rst_cap = 1'b1;
    logic [7:0] last_data = 8'h00;

`ifdef GRAY_ROUND_EN
    localparam logic [7:0] EXP_010 = 8'h01;
`else
    localparam logic [7:0] EXP_010 = 8'h00;
`endif

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_cap <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: runs half a cycle after each active edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_cap) begin
            last_data = 8'h00;
            chk("reset_state", {out_valid, out_eol, out_eof, out_data}, 32'h0);
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pixel_data", out_data, e.data);
                chk("pixel_eol",  out_eol,  e.eol);
                chk("pixel_eof",  out_eof,  e.eof);
                chk("pixel_cycle", cyc, e.cyc);
                last_data = e.data;
            end
        end else begin
            chk("idle_hold", {out_eol, out_eof, out_data}, {2'b00, last_data});
            if (q.size() != 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("missing_pulse", 32'd0, 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit sof, input bit last,
                             input logic [7:0] exp);
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        if (sof) pos = 0;
        if (last) begin
            e.data = exp;
            e.eol  = ((pos % TW) == TW - 1);
            e.eof  = (pos == TW * TH - 1);
            e.cyc  = cyc + 1;
            q.push_back(e);
            pos = (pos + 1) % (TW * TH);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'hAA;
    endtask

    task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [7:0] exp, input bit sof);
        send_byte(r, sof, 1'b0, 8'h00);
        send_byte(g, 1'b0, 1'b0, 8'h00);
        send_byte(b, 1'b0, 1'b1, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pos = 0;

        // Continuous triples, pulses 3 clocks apart
        send_pix(8'd255, 8'd255, 8'd255, 8'hFF, 1'b0);
        send_pix(8'd1,   8'd1,   8'd1,   8'h01, 1'b0);
        send_pix(8'd100, 8'd50,  8'd200, 8'h52, 1'b0);
        send_pix(8'd0,   8'd1,   8'd0,   EXP_010, 1'b0);
        send_pix(8'd0,   8'd0,   8'd9,   8'h01, 1'b0);
        idle(2);

        // Gapped input
        send_byte(8'd255, 1'b0, 1'b0, 8'h00);
        idle(2);
        send_byte(8'd255, 1'b0, 1'b0, 8'h00);
        idle(5);
        send_byte(8'd255, 1'b0, 1'b1, 8'hFF);
        idle(3);

        // in_sof without in_valid must be ignored
        send_byte(8'd100, 1'b0, 1'b0, 8'h00);
        in_sof = 1'b1;
        idle(1);
        in_sof = 1'b0;
        send_byte(8'd50, 1'b0, 1'b0, 8'h00);
        send_byte(8'd200, 1'b0, 1'b1, 8'h52);
        idle(2);

        // Nine continuous pixels from frame start: line and frame markers
        send_pix(8'h03, 8'h03, 8'h03, 8'h03, 1'b1);
        for (int i = 1; i < 9; i++) begin
            send_pix(8'(i * 16 + 3), 8'(i * 16 + 3), 8'(i * 16 + 3), 8'(i * 16 + 3), 1'b0);
        end
        idle(2);

        // Mid-triple in_sof discards the partial pixel and restarts the counters
        send_byte(8'd10, 1'b0, 1'b0, 8'h00);
        send_byte(8'd20, 1'b0, 1'b0, 8'h00);
        send_pix(8'd255, 8'd255, 8'd255, 8'hFF, 1'b1);
        send_pix(8'd7, 8'd7, 8'd7, 8'h07, 1'b0);
        send_pix(8'd8, 8'd8, 8'd8, 8'h08, 1'b0);
        send_pix(8'd9, 8'd9, 8'd9, 8'h09, 1'b0);
        idle(2);

        // Reset after R,G discards the partial triple
        send_byte(8'd5, 1'b0, 1'b0, 8'h00);
        send_byte(8'd6, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        pos = 0;
        idle(1);
        send_pix(8'd1, 8'd1, 8'd1, 8'h01, 1'b0);
        idle(2);

        // A B byte captured together with rst produces no pulse
        send_byte(8'd7, 1'b0, 1'b0, 8'h00);
        send_byte(8'd8, 1'b0, 1'b0, 8'h00);
        in_valid = 1'b1;
        in_data  = 8'd9;
        rst      = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        pos      = 0;
        idle(2);
        send_pix(8'd2, 8'd2, 8'd2, 8'h02, 1'b0);

        idle(6);
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
